// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared constants for alu_mdu_unit: main-decoder op codes, R-type funct
//   values, ALU/MDU control codes, FSM state encoding and the control decoder.
//   No ports.
package alu_pkg;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  localparam logic [3:0] CTL_AND   = 4'b0000;
  localparam logic [3:0] CTL_OR    = 4'b0001;
  localparam logic [3:0] CTL_ADD   = 4'b0010;
  localparam logic [3:0] CTL_XOR   = 4'b0011;
  localparam logic [3:0] CTL_ADDU  = 4'b0100;
  localparam logic [3:0] CTL_SUBU  = 4'b0101;
  localparam logic [3:0] CTL_SUB   = 4'b0110;
  localparam logic [3:0] CTL_SLT   = 4'b0111;
  localparam logic [3:0] CTL_SLTU  = 4'b1000;
  localparam logic [3:0] CTL_MULT  = 4'b1001;
  localparam logic [3:0] CTL_MULTU = 4'b1010;
  localparam logic [3:0] CTL_DIV   = 4'b1011;
  localparam logic [3:0] CTL_DIVU  = 4'b1100;
  localparam logic [3:0] CTL_MFHI  = 4'b1101;
  localparam logic [3:0] CTL_MFLO  = 4'b1110;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_MUL  = 2'b01;
  localparam logic [1:0] ST_DIV  = 2'b10;
  localparam logic [1:0] ST_FIX  = 2'b11;

  function automatic logic [3:0] decode_ctrl(input logic [1:0] op, input logic [5:0] funct);
    logic [3:0] c;
    c = CTL_AND;
    case (op)
      OP_ADD: c = CTL_ADD;
      OP_SUB: c = CTL_SUB;
      OP_RTYPE: begin
        case (funct)
          F_ADD:   c = CTL_ADD;
          F_ADDU:  c = CTL_ADDU;
          F_SUB:   c = CTL_SUB;
          F_SUBU:  c = CTL_SUBU;
          F_AND:   c = CTL_AND;
          F_OR:    c = CTL_OR;
          F_XOR:   c = CTL_XOR;
          F_SLT:   c = CTL_SLT;
          F_SLTU:  c = CTL_SLTU;
          F_MULT:  c = CTL_MULT;
          F_MULTU: c = CTL_MULTU;
          F_DIV:   c = CTL_DIV;
          F_DIVU:  c = CTL_DIVU;
          F_MFHI:  c = CTL_MFHI;
          F_MFLO:  c = CTL_MFLO;
          default: c = CTL_AND;
        endcase
      end
      default: c = CTL_AND;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter
//   Iterative multiply/divide datapath working on operand magnitudes: radix-2
//   shift-add multiply and restoring divide, one bit per cycle for WIDTH cycles.
//   Results are raw (unsigned); the sign flags tell the caller how to correct.
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start           load operands and begin (ignored by nothing; caller gates)
//   sgn, is_div     signed operation / divide (else multiply)
//   a, b            operands, sampled on start
//   done            high during the last iteration cycle
//   raw_hi, raw_lo  product {hi,lo}, or remainder (hi) / quotient (lo)
//   neg_q, neg_r    product-or-quotient / remainder must be negated
//   b_zero          divisor was zero
//   div_q           latched is_div
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] raw_hi,
  output logic [WIDTH-1:0] raw_lo,
  output logic             neg_q,
  output logic             neg_r,
  output logic             b_zero,
  output logic             div_q
);

  localparam int CW = $clog2(WIDTH);

  logic             busy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] mag_b;

  logic [WIDTH-1:0] mag_a_in;
  logic [WIDTH-1:0] mag_b_in;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             fits;

  assign mag_a_in = (sgn && a[WIDTH-1]) ? -a : a;
  assign mag_b_in = (sgn && b[WIDTH-1]) ? -b : b;

  // Multiply: {acc,quo} holds the partial product with the multiplier in quo.
  assign add_sum = {1'b0, acc} + (quo[0] ? {1'b0, mag_b} : {(WIDTH+1){1'b0}});

  // Divide: acc is the partial remainder, quo shifts dividend out / quotient in.
  assign shifted = {acc, quo[WIDTH-1]};
  assign fits    = (shifted >= {1'b0, mag_b});
  assign diff    = shifted - {1'b0, mag_b};

  assign done   = busy && (cnt == '0);
  assign raw_hi = acc;
  assign raw_lo = quo;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      quo    <= '0;
      mag_b  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      div_q  <= 1'b0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= CW'(WIDTH - 1);
      acc    <= '0;
      quo    <= mag_a_in;
      mag_b  <= mag_b_in;
      neg_q  <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r  <= sgn && a[WIDTH-1];
      b_zero <= (b == '0);
      div_q  <= is_div;
    end else if (busy) begin
      cnt <= cnt - 1'b1;
      if (cnt == '0) busy <= 1'b0;
      if (div_q) begin
        if (fits) begin
          acc <= WIDTH'(diff);
          quo <= {quo[WIDTH-2:0], 1'b1};
        end else begin
          acc <= WIDTH'(shifted);
          quo <= {quo[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc <= WIDTH'(add_sum >> 1);
        quo <= {add_sum[0], quo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/alu_mdu_unit.sv
// alu_mdu_unit
//   Single-cycle ALU plus iterative multiply/divide unit with HI/LO registers.
//   ALU ops and mfhi/mflo complete the cycle after acceptance; mult/div take
//   WIDTH+2 cycles and only update HI/LO.
// Ports
//   clk, rst       clock, synchronous active-high reset
//   valid_in       request qualifier; accepted when ready_in is high
//   ready_in       high only in IDLE
//   op, funct      main-decoder op and R-type function field
//   a, b           operands (rs, rt)
//   control        control code of the last accepted ALU/mfhi/mflo op
//   result         registered result
//   result_valid   one-cycle completion pulse
//   hi, lo         HI/LO registers
//   div_zero       last divide had b = 0; cleared on the next acceptance
//
// state | meaning
// IDLE  | accepting requests
// MUL   | multiply iterations running
// DIV   | divide iterations running
// FIX   | sign correction, HI/LO write
module alu_mdu_unit #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [1:0]        op,
  input  logic [5:0]        funct,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic [CTRL_W-1:0] control,
  output logic [WIDTH-1:0]  result,
  output logic              result_valid,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo,
  output logic              div_zero
);

  import alu_pkg::*;

  logic [1:0]       state;
  logic [3:0]       dec;
  logic             accept;
  logic             is_mul;
  logic             is_div;
  logic             is_sgn;
  logic             mdu_start;
  logic [WIDTH-1:0] alu_out;

  logic             mdu_done;
  logic [WIDTH-1:0] raw_hi;
  logic [WIDTH-1:0] raw_lo;
  logic             neg_q;
  logic             neg_r;
  logic             b_zero;
  logic             div_q;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  assign dec       = decode_ctrl(op, funct);
  assign ready_in  = (state == ST_IDLE);
  assign accept    = valid_in && ready_in;
  assign is_mul    = (dec == CTL_MULT) || (dec == CTL_MULTU);
  assign is_div    = (dec == CTL_DIV)  || (dec == CTL_DIVU);
  assign is_sgn    = (dec == CTL_MULT) || (dec == CTL_DIV);
  assign mdu_start = accept && (is_mul || is_div);

  always_comb begin
    alu_out = '0;
    case (dec)
      CTL_ADD, CTL_ADDU: alu_out = a + b;
      CTL_SUB, CTL_SUBU: alu_out = a - b;
      CTL_AND:           alu_out = a & b;
      CTL_OR:            alu_out = a | b;
      CTL_XOR:           alu_out = a ^ b;
      CTL_SLT:           alu_out = WIDTH'($signed(a) < $signed(b));
      CTL_SLTU:          alu_out = WIDTH'(a < b);
      CTL_MFHI:          alu_out = hi;
      CTL_MFLO:          alu_out = lo;
      default:           alu_out = a & b;
    endcase
  end

  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk    (clk),
    .rst    (rst),
    .start  (mdu_start),
    .sgn    (is_sgn),
    .is_div (is_div),
    .a      (a),
    .b      (b),
    .done   (mdu_done),
    .raw_hi (raw_hi),
    .raw_lo (raw_lo),
    .neg_q  (neg_q),
    .neg_r  (neg_r),
    .b_zero (b_zero),
    .div_q  (div_q)
  );

  // Divide-by-zero: the raw remainder ends up as |a|, so negating it by a's
  // sign restores a exactly (including the most-negative value).
  assign prod_fix = neg_q ? -{raw_hi, raw_lo} : {raw_hi, raw_lo};
  assign q_fix    = b_zero ? '1 : (neg_q ? -raw_lo : raw_lo);
  assign r_fix    = neg_r ? -raw_hi : raw_hi;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      result       <= '0;
      result_valid <= 1'b0;
      hi           <= '0;
      lo           <= '0;
      control      <= '0;
      div_zero     <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            div_zero <= 1'b0;
            if (is_mul) begin
              state <= ST_MUL;
            end else if (is_div) begin
              state <= ST_DIV;
            end else begin
              result       <= alu_out;
              control      <= CTRL_W'(dec);
              result_valid <= 1'b1;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (mdu_done) state <= ST_FIX;
        end
        ST_FIX: begin
          state        <= ST_IDLE;
          result_valid <= 1'b1;
          if (div_q) begin
            lo       <= q_fix;
            hi       <= r_fix;
            div_zero <= b_zero;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
